// File: rtl/imem_load_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | imem_load_ctrl: loads a big-endian byte stream into instruction memory  |
// | while stalling the CPU, then hands the read port to instruction fetch.  |
// | Optional readback check enabled by defining IMEM_READBACK_EN.           |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module imem_load_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic [ADDR_W-1:0] cpu_pc_addr,
  output logic [DATA_W-1:0] cpu_instr,
  output logic              cpu_stall,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_d,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_dpra,
  input  logic [DATA_W-1:0] mem_dpo,
  output logic              busy,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [2:0] {
    S_BOOT_WAIT = 3'd0,
    S_LOAD      = 3'd1,
    S_WRITE     = 3'd2,
    S_VERIFY    = 3'd3,
    S_RUN       = 3'd4
  } state_t;

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W:0]     wc_q, wc_d;
  logic [1:0]          bidx_q, bidx_d;
  logic [DATA_W-1:0]   asm_q, asm_d;
  logic                done_q, done_d;
  logic [ADDR_W:0]     eff_len;

`ifdef IMEM_READBACK_EN
  logic [DATA_W-1:0]   csum_q, csum_d;
  logic [DATA_W-1:0]   rbx_q, rbx_d;
  logic [ADDR_W:0]     vaddr_q, vaddr_d;
  logic                err_q, err_d;
`endif

  // Any request of 2^ADDR_W words or more fills the whole memory.
  assign eff_len = load_len[ADDR_W] ? MAX_LEN : load_len;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wc_d    = wc_q;
    bidx_d  = bidx_q;
    asm_d   = asm_q;
    done_d  = 1'b0;
`ifdef IMEM_READBACK_EN
    csum_d  = csum_q;
    rbx_d   = rbx_q;
    vaddr_d = vaddr_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_BOOT_WAIT, S_RUN: begin
        if (load_start) begin
          len_d  = eff_len;
          wc_d   = '0;
          bidx_d = '0;
          asm_d  = '0;
`ifdef IMEM_READBACK_EN
          csum_d = '0;
          err_d  = 1'b0;
`endif
          if (eff_len == '0) begin
            state_d = S_RUN;
            done_d  = 1'b1;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (byte_valid) begin
          asm_d  = {asm_q[DATA_W-9:0], byte_data};
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        wc_d = wc_q + LEN_ONE;
`ifdef IMEM_READBACK_EN
        csum_d = csum_q ^ asm_q;
`endif
        if (wc_d == len_q) begin
`ifdef IMEM_READBACK_EN
          state_d = S_VERIFY;
          vaddr_d = '0;
          rbx_d   = '0;
`else
          state_d = S_RUN;
          done_d  = 1'b1;
`endif
        end else begin
          state_d = S_LOAD;
        end
      end
`ifdef IMEM_READBACK_EN
      S_VERIFY: begin
        rbx_d   = rbx_q ^ mem_dpo;
        vaddr_d = vaddr_q + LEN_ONE;
        if (vaddr_q == len_q - LEN_ONE) begin
          state_d = S_RUN;
          done_d  = 1'b1;
          err_d   = (rbx_d != csum_q);
        end
      end
`endif
      default: state_d = S_BOOT_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_BOOT_WAIT;
      len_q   <= '0;
      wc_q    <= '0;
      bidx_q  <= '0;
      asm_q   <= '0;
      done_q  <= 1'b0;
`ifdef IMEM_READBACK_EN
      csum_q  <= '0;
      rbx_q   <= '0;
      vaddr_q <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wc_q    <= wc_d;
      bidx_q  <= bidx_d;
      asm_q   <= asm_d;
      done_q  <= done_d;
`ifdef IMEM_READBACK_EN
      csum_q  <= csum_d;
      rbx_q   <= rbx_d;
      vaddr_q <= vaddr_d;
      err_q   <= err_d;
`endif
    end
  end

  // Handshake and stall outputs come only from the registered state.
  assign byte_ready = (state_q == S_LOAD);
  assign mem_we     = (state_q == S_WRITE);
  assign busy       = (state_q == S_LOAD) || (state_q == S_WRITE) || (state_q == S_VERIFY);
  assign cpu_stall  = (state_q != S_RUN);
  assign mem_a      = wc_q[ADDR_W-1:0];
  assign mem_d      = asm_q;
  assign cpu_instr  = (state_q == S_RUN) ? mem_dpo : '0;
  assign load_done  = done_q;
  assign word_count = wc_q;

`ifdef IMEM_READBACK_EN
  assign mem_dpra   = (state_q == S_VERIFY) ? vaddr_q[ADDR_W-1:0] : cpu_pc_addr;
  assign load_error = err_q;
`else
  assign mem_dpra   = cpu_pc_addr;
  assign load_error = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/imem_load_ctrl.md
# imem_load_ctrl

Boot/reload controller that owns the instruction memory's write and read ports. It loads a program from a byte stream into instruction memory while holding the CPU in stall, then hands the read port to CPU instruction fetch. It sits between the byte source (UART receiver or testbench) and the CPU on one side, and the 1024 × 32 distributed instruction memory on the other. The memory has a synchronous write port and an asynchronous read port.

## Interface
- ADDR_W, 10, word-address width of instruction memory (depth 2^ADDR_W)
- DATA_W, 32, instruction width; fixed 4 bytes per word

- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- load_start  in  1  one-cycle request to begin a load; honoured only in BOOT_WAIT or RUN
- load_len  in  ADDR_W+1  number of words to load, latched on accepted load_start
- byte_valid  in  1  byte_data valid
- byte_data  in  8  program byte, big-endian within word
- byte_ready  out  1  controller accepts byte this cycle
- cpu_pc_addr  in  ADDR_W  CPU fetch word address
- cpu_instr  out  DATA_W  fetched instruction
- cpu_stall  out  1  CPU must hold PC
- mem_a  out  ADDR_W  memory write address
- mem_d  out  DATA_W  memory write data
- mem_we  out  1  memory write enable
- mem_dpra  out  ADDR_W  memory read address
- mem_dpo  in  DATA_W  memory read data (combinational from mem_dpra)
- busy  out  1  high in LOAD, WRITE, VERIFY
- load_done  out  1  one-cycle pulse when a load completes
- load_error  out  1  readback mismatch flag (sticky)
- word_count  out  ADDR_W+1  words written in current/last load

## Operation
- States: BOOT_WAIT, LOAD, WRITE, VERIFY, RUN.
- BOOT_WAIT (reset state): cpu_stall=1. Accepted load_start moves to LOAD.
- On accepted load_start: latch len = min(load_len, 2^ADDR_W); clear word_count, byte index, checksum, load_error.
- If len=0, go directly to RUN with a load_done pulse and no writes.
- LOAD: byte_ready=1. On byte_valid&&byte_ready, shift byte into assembly register: 1st byte → [31:24] … 4th byte → [7:0].
- After the 4th byte, go to WRITE.
- WRITE (1 cycle): mem_we=1, mem_a=word_count[ADDR_W-1:0], mem_d=assembled word. checksum ^= word. word_count += 1.
- From WRITE: if the new word_count == len, go to RUN (or VERIFY, see Configuration); else return to LOAD.
- RUN: cpu_stall=0, mem_dpra=cpu_pc_addr, cpu_instr=mem_dpo. Accepted load_start re-enters LOAD; the CPU is stalled from the next cycle on.
- Outside RUN: cpu_instr=32'h0000_0000 (NOP), mem_dpra=cpu_pc_addr (or the verify address in VERIFY).
- load_start is ignored in LOAD, WRITE and VERIFY. byte_valid is ignored while byte_ready=0.
- Reset mid-load returns to BOOT_WAIT. The partial word is discarded. Already-written memory words are not cleared.

## Timing
- Reset values: state=BOOT_WAIT, cpu_stall=1, byte_ready=0, mem_we=0, mem_a=0, mem_d=0, busy=0, load_done=0, load_error=0, word_count=0, cpu_instr=0.
- cpu_stall, byte_ready, mem_we and busy are decoded from the registered state; there is no combinational path from byte_valid or load_start.
- Per word: at least 4 byte-accept cycles plus 1 WRITE cycle. byte_ready=0 during WRITE.
- load_done is high for exactly the first cycle of RUN after a load. cpu_stall falls in that same cycle.
- A write in WRITE cycle N is visible on the async read port from cycle N+1.

## Configuration
- IMEM_READBACK_EN defined:
  - After the last WRITE, enter VERIFY for len cycles. Cycle k drives mem_dpra=k and XOR-accumulates mem_dpo.
  - On exit to RUN, load_error = (readback XOR != write checksum).
  - load_done pulses on entry to RUN.
- IMEM_READBACK_EN undefined:
  - The VERIFY state is absent. WRITE goes directly to RUN.
  - load_error is constant 0.

## Test plan
- Reset, then load_start with load_len=2 and bytes 20,08,00,05,00,00,00,00 → writes 0x20080005 at addr 0 and 0x00000000 at addr 1; load_done pulses once; cpu_stall falls; word_count=2.
- In RUN, cpu_pc_addr=0 → cpu_instr=0x20080005 in the same cycle. Before any load, cpu_instr=0 and cpu_stall=1.
- load_len=0 → RUN on the next cycle, load_done=1, mem_we never asserted.
- load_len=1024 with byte_valid toggling every other cycle → 1024 writes, addresses wrap-free 0..1023. Then load_start with load_len=2047 → clamped to 1024 writes.
- rst pulsed after 2 bytes of word 3 → BOOT_WAIT next cycle, no further mem_we, words 0–2 retained. A second load_start while busy is ignored.
- With IMEM_READBACK_EN, force mem_dpo bit 0 inverted during VERIFY → load_error=1 together with load_done. Without the macro, load_error stays 0.
